// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared LC-3b memory-interface types: word, cacheline, line
//               offset width, memory op and responder FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;

    localparam int LC3B_LINE_OFFSET_BITS = 4;

    typedef enum logic {
        MEM_OP_READ  = 1'b0,
        MEM_OP_WRITE = 1'b1
    } lc3b_mem_op;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lc3b_mem_resp_state;

endpackage
`default_nettype wire

// File: rtl/cacheline_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_mem_array
// Description : 2^INDEX_BITS x 128-bit single-port line store with write
//               enable and a registered, read-enabled output.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_mem_array #(
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [INDEX_BITS-1:0] i_index,
    input  logic [127:0]          i_wdata,
    output logic [127:0]          o_rdata
);

    logic [127:0] r_mem [0:(1 << INDEX_BITS) - 1];
    logic [127:0] r_rdata;

    // Line storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_index] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_index];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cacheline_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_mem_responder
// Description : Cacheline memory slave; services one 128-bit line read or
//               write after LATENCY cycles and pulses mem_resp.
//               Optional macro CACHELINE_MEM_RESP_STATS_EN adds saturating
//               read/write completion counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_mem_responder
    import lc3b_types::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int LATENCY    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic         mem_resp,
    output logic [127:0] mem_rdata
`ifdef CACHELINE_MEM_RESP_STATS_EN
    ,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
`endif
);

    localparam logic [1:0]  c_ST_IDLE    = 2'(IDLE);
    localparam logic [1:0]  c_ST_BUSY    = 2'(BUSY);
    localparam logic [1:0]  c_ST_RESP    = 2'(RESP);
    localparam logic [7:0]  c_LAT_INIT   = 8'(LATENCY - 1);
    localparam logic        c_DIRECT     = (LATENCY == 1);
    localparam logic [15:0] c_INDEX_MASK =
        16'(((1 << INDEX_BITS) - 1) << LC3B_LINE_OFFSET_BITS);

    logic [1:0]            r_state;
    logic [7:0]            r_count;
    lc3b_mem_op            r_op;
    logic [INDEX_BITS-1:0] r_index;
    logic [127:0]          r_wdata;

    logic                  w_req;
    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_is_write;
    logic [INDEX_BITS-1:0] w_req_index;
    logic [INDEX_BITS-1:0] w_index;
    logic [127:0]          w_wdata;
    logic                  w_unused_addr;

    assign w_req       = mem_read | mem_write;
    assign w_accept    = (r_state == c_ST_IDLE) && w_req;
    assign w_req_index = mem_address[INDEX_BITS+LC3B_LINE_OFFSET_BITS-1:LC3B_LINE_OFFSET_BITS];
    // Offset bits and address bits above the index alias silently.
    assign w_unused_addr = ^(mem_address & ~c_INDEX_MASK);

    // With LATENCY=1 the array is accessed on the accepting edge itself,
    // so the live request fields are steered straight through.
    assign w_enter_resp = (w_accept && c_DIRECT) ||
                          ((r_state == c_ST_BUSY) && (r_count == 8'd1));
    assign w_is_write   = (r_state == c_ST_IDLE) ? mem_write : (r_op == MEM_OP_WRITE);
    assign w_index      = (r_state == c_ST_IDLE) ? w_req_index : r_index;
    assign w_wdata      = (r_state == c_ST_IDLE) ? mem_wdata : r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_count <= 8'd0;
            r_op    <= MEM_OP_READ;
            r_index <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= mem_write ? MEM_OP_WRITE : MEM_OP_READ;
                        r_index <= w_req_index;
                        r_wdata <= mem_wdata;
                        r_count <= c_LAT_INIT;
                        r_state <= c_DIRECT ? c_ST_RESP : c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    r_count <= r_count - 8'd1;
                    if (r_count == 8'd1) begin
                        r_state <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign mem_resp = (r_state == c_ST_RESP);

    cacheline_mem_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_enter_resp & w_is_write),
        .i_re    (w_enter_resp & ~w_is_write),
        .i_index (w_index),
        .i_wdata (w_wdata),
        .o_rdata (mem_rdata)
    );

`ifdef CACHELINE_MEM_RESP_STATS_EN
    logic [15:0] r_read_count;
    logic [15:0] r_write_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_count  <= 16'd0;
            r_write_count <= 16'd0;
        end else if (r_state == c_ST_RESP) begin
            if (r_op == MEM_OP_WRITE) begin
                if (r_write_count != 16'hFFFF) r_write_count <= r_write_count + 16'd1;
            end else begin
                if (r_read_count != 16'hFFFF) r_read_count <= r_read_count + 16'd1;
            end
        end
    end

    assign read_count  = r_read_count;
    assign write_count = r_write_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cacheline_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_mem_responder
// Description : Scoreboard bench for cacheline_mem_responder (LATENCY=4
//               instance) plus a LATENCY=1 back-to-back instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_mem_responder;

    localparam int LAT = 4;
    localparam logic [127:0] P_D = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    localparam logic [127:0] P_A = 128'hAAAA_5555_AAAA_5555_1111_2222_3333_4444;
    localparam logic [127:0] P_B = 128'hBBBB_0000_FFFF_1234_5678_9ABC_DEF0_0B0B;
    localparam logic [127:0] P_E = 128'hEEEE_EEEE_0000_0000_1357_9BDF_2468_ACE0;
    localparam logic [127:0] P_C = 128'hC0C0_C0C0_0C0C_0C0C_FEED_FACE_CAFE_F00D;
    localparam logic [127:0] P_F = 128'hF00D_0001_0002_0003_0004_0005_0006_0007;
    localparam logic [127:0] P_G = 128'h6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
    localparam logic [127:0] P_H = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rst1_n = 1'b0;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [15:0]  mem_address = 16'd0;
    logic [127:0] mem_wdata = '0;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic         d1_read = 1'b0, d1_write = 1'b0;
    logic [15:0]  d1_address = 16'd0;
    logic [127:0] d1_wdata = '0;
    logic         d1_resp;
    logic [127:0] d1_rdata;
`ifdef CACHELINE_MEM_RESP_STATS_EN
    logic [15:0]  rc, wc, rc1, wc1;
`endif

    cacheline_mem_responder #(.INDEX_BITS(8), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
`ifdef CACHELINE_MEM_RESP_STATS_EN
        , .read_count(rc), .write_count(wc)
`endif
    );

    cacheline_mem_responder #(.INDEX_BITS(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .mem_read(d1_read), .mem_write(d1_write),
        .mem_address(d1_address), .mem_wdata(d1_wdata),
        .mem_resp(d1_resp), .mem_rdata(d1_rdata)
`ifdef CACHELINE_MEM_RESP_STATS_EN
        , .read_count(rc1), .write_count(wc1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [127:0] rdata;
        int           cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Monitor: every resp pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_resp) begin
            if (sb.size() == 0) begin
                check("spurious_resp", 128'(mem_resp), 128'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_rdata", mem_rdata, mon_e.rdata);
                check("resp_cycle", 128'(cyc), 128'(mon_e.cyc));
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [127:0] wd, input logic [127:0] exp_rd, input bit churn);
        exp_t e;
        bit   seen;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd;
        e.rdata = exp_rd;
        e.cyc   = cyc + LAT;
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_resp) seen = 1'b1;
            else if (churn) begin
                mem_address = 16'($urandom);
                mem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        if (!seen) check("resp_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_resp", 128'(mem_resp), 128'd0);
        check("reset_rdata", mem_rdata, 128'd0);
        check("reset_resp_l1", 128'(d1_resp), 128'd0);
        rst_n = 1'b1; rst1_n = 1'b1;

        do_req(1'b0, 1'b1, 16'h0120, P_D, 128'd0, 1'b0);
        do_req(1'b1, 1'b0, 16'h012C, '0,  P_D,    1'b0);
        // Aliasing: 0x1010 and 0x0010 share line index 0x01.
        do_req(1'b0, 1'b1, 16'h1010, P_A, P_D, 1'b0);
        do_req(1'b1, 1'b0, 16'h0010, '0,  P_A, 1'b0);
        do_req(1'b0, 1'b1, 16'h0020, P_B, P_A, 1'b0);
        do_req(1'b1, 1'b0, 16'h0010, '0,  P_A, 1'b0);
        do_req(1'b1, 1'b0, 16'h0020, '0,  P_B, 1'b0);
        // Read and write together: write wins, rdata holds.
        do_req(1'b1, 1'b1, 16'h0040, P_E, P_B, 1'b0);
        do_req(1'b1, 1'b0, 16'h0040, '0,  P_E, 1'b0);
        do_req(1'b0, 1'b1, 16'h0300, P_C, P_E, 1'b1);
        do_req(1'b1, 1'b0, 16'h0300, '0,  P_C, 1'b0);
        do_req(1'b0, 1'b1, 16'h0200, P_F, P_C, 1'b0);
        do_req(1'b1, 1'b0, 16'h0200, '0,  P_F, 1'b0);

        // Abort a write to 0x0200 while busy.
        @(negedge clk);
        mem_write = 1'b1; mem_address = 16'h0200; mem_wdata = P_G;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; mem_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_resp", 128'(mem_resp), 128'd0);
            check("abort_rdata", mem_rdata, 128'd0);
        end
        rst_n = 1'b1;
        do_req(1'b1, 1'b0, 16'h0200, '0, P_F, 1'b0);
`ifdef CACHELINE_MEM_RESP_STATS_EN
        check("stats_read", 128'(rc), 128'd1);
        check("stats_write", 128'(wc), 128'd0);
`endif

        // LATENCY=1 instance: preload, reset (array retained), then stream reads.
        @(negedge clk);
        d1_write = 1'b1; d1_address = 16'h0050; d1_wdata = P_H;
        @(negedge clk);
        check("l1_write_resp", 128'(d1_resp), 128'd1);
        d1_write = 1'b0;
        @(negedge clk);
        check("l1_idle", 128'(d1_resp), 128'd0);
        rst1_n = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        check("l1_reset_rdata", d1_rdata, 128'd0);
        @(negedge clk);
        d1_read = 1'b1; d1_address = 16'h0050;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("l1_resp_pattern", 128'(d1_resp), 128'(i % 2 == 0));
            if (i % 2 == 0) check("l1_rdata", d1_rdata, P_H);
        end
        d1_read = 1'b0;
        @(negedge clk);
        check("l1_rdata_hold", d1_rdata, P_H);
        check("l1_no_resp", 128'(d1_resp), 128'd0);
`ifdef CACHELINE_MEM_RESP_STATS_EN
        check("l1_stats_read", 128'(rc1), 128'd5);
        check("l1_stats_write", 128'(wc1), 128'd0);
`endif

        repeat (6) @(negedge clk);
        check("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cacheline_mem_responder.md
Name: cacheline_mem_responder

Overview:
- Synthesizable responder for the cacheline memory protocol, i.e. the slave end of the super_mem_* interface driven by the eviction buffer.
- Accepts one 128-bit line read or write at a time.
- Services it from an internal line array after a fixed, parameterized latency, then pulses resp.
- Stands in for physical memory in integrated builds and serves as the reference slave for eviction-buffer / L2 verification.

Parameters:
- INDEX_BITS, 8, log2 of the number of lines stored (default 256 lines = 4 KB).
- LATENCY, 4, cycles from request acceptance to resp pulse; legal range 1..255.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active low.
- mem_read  input  1  line read request, held by the requester until resp.
- mem_write  input  1  line write request, held by the requester until resp.
- mem_address  input  16 (lc3b_word)  byte address; bits [3:0] ignored.
- mem_wdata  input  128 (lc3b_cacheline)  write line.
- mem_resp  output  1  one-cycle completion pulse.
- mem_rdata  output  128 (lc3b_cacheline)  read line, valid in the resp cycle and held until the next read completes.

Behaviour:
- Reset (async on rst_n low):
  - state=IDLE, mem_resp=0, mem_rdata=0, latency counter=0, latched request cleared.
  - Array contents are NOT reset.
  - Reset mid-operation aborts the transaction: no resp, and no array write unless the write already committed.
- FSM IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If mem_read or mem_write is high at a clock edge, latch op, address index, and wdata.
  - Load the counter with LATENCY-1 and go to BUSY; if LATENCY=1, go directly to RESP.
  - If both are high, the op is a write; the read is dropped and gets no resp.
- BUSY:
  - Decrement the counter each cycle; go to RESP when it reaches 0.
  - Input changes are ignored; the latched values are used.
- RESP:
  - mem_resp=1 for exactly one cycle, i.e. a request first seen at edge t produces mem_resp high in cycle t+LATENCY.
  - Read: mem_rdata is registered from array[index] on the edge entering RESP.
  - Write: array[index] is updated on the edge entering RESP, so the write is visible to any request accepted afterwards. mem_rdata is unchanged.
  - Return to IDLE.
- Back-to-back: a request still asserted in the cycle after RESP is treated as a new transaction. Requesters must drop or change the request on seeing resp, consistent with the protocol's one-pulse-per-transaction rule.
- Address map:
  - index = mem_address[INDEX_BITS+3:4].
  - Address bits above the index alias; no error is raised.
- No partial writes; full 128-bit line only.
- Latency counter width is 8 bits.
- mem_resp never asserts in IDLE or BUSY.

Optional Feature:
- Macro CACHELINE_MEM_RESP_STATS_EN.
- Defined:
  - Adds output ports read_count[15:0] and write_count[15:0].
  - Each increments on a RESP cycle of the matching op and saturates at 16'hFFFF.
  - Both reset to 0 via rst_n.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- lc3b_types already supplies lc3b_word and lc3b_cacheline.
- Add to lc3b_types:
  - LC3B_LINE_OFFSET_BITS = 4.
  - lc3b_mem_op enum {MEM_OP_READ, MEM_OP_WRITE}.
  - State enum lc3b_mem_resp_state {IDLE, BUSY, RESP}.
- One sub-module: cacheline_mem_array, a 2^INDEX_BITS x 128 synchronous single-port array with write enable, index, wdata, and registered rdata.
- FSM, counter, and request latch live in the top module.

Test Plan:
- Write then read, LATENCY=4:
  - Write addr 16'h0120, wdata 128'hDEAD..BEEF, at edge 0 -> mem_resp high in cycle 4 only.
  - Then read 16'h012C -> resp in cycle 4 of the read, mem_rdata = 128'hDEAD..BEEF.
- Aliasing, INDEX_BITS=8: write 16'h1010 with pattern A -> read 16'h0010 returns A. Write 16'h0020 -> line 0x01 is unchanged.
- Simultaneous read+write high: write is performed, exactly one resp is produced, and mem_rdata keeps its previous value.
- Input churn in BUSY: change mem_address and mem_wdata every cycle after acceptance -> the latched original address and data are used.
- Reset mid-operation:
  - Assert rst_n=0 in BUSY of a write to 16'h0200 -> mem_resp stays 0 and mem_rdata=0.
  - A later read of 16'h0200 returns the old contents.
- LATENCY=1 back-to-back reads held continuously:
  - mem_resp is high every other cycle.
  - With CACHELINE_MEM_RESP_STATS_EN defined, read_count=N after N pulses and write_count=0.
